// File: rtl/step_pulse_conditioner.sv
// =============================================================================
// step_pulse_conditioner -- sync, debounce and refractory filter for step pulses
// Revision 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_pulse_conditioner #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_WIDTH     = 4,
   parameter int MIN_GAP_CYCLES  = 64,
   parameter int CNT_W           = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             raw_step,
   input  logic             enable,
   output logic             pulseOut,
   output logic             step_valid,
   output logic             debounced,
   output logic [CNT_W-1:0] accepted_count,
   output logic [7:0]       reject_count
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GAP_W = $clog2(MIN_GAP_CYCLES + 1);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
   localparam logic [GAP_W-1:0] G_ONE   = GAP_W'(1);
   localparam logic [GAP_W-1:0] G_PW    = GAP_W'(PULSE_WIDTH);
   localparam logic [GAP_W-1:0] G_GAP   = GAP_W'(MIN_GAP_CYCLES);
   localparam logic [CNT_W-1:0] ACC_ONE = CNT_W'(1);
   localparam logic [7:0]       REJ_MAX = 8'hFF;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] PULSE = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic [DB_W-1:0]        db_cnt;
   logic                   debounced_q;
   logic                   rise;
   logic [1:0]             state;
   logic [GAP_W-1:0]       g;
   logic                   accept;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw_step};
      end
   end

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_cnt    <= '0;
         debounced <= 1'b0;
      end else if (s == debounced) begin
         db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
         debounced <= s;
         db_cnt    <= '0;
      end else begin
         db_cnt <= db_cnt + DB_ONE;
      end
   end

   // Edge strobe is registered so the FSM sees a clean single-cycle event.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         debounced_q <= 1'b0;
         rise        <= 1'b0;
      end else begin
         debounced_q <= debounced;
         rise        <= debounced & ~debounced_q;
      end
   end

   assign accept = rise && enable && (state == IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         g              <= '0;
         pulseOut       <= 1'b0;
         step_valid     <= 1'b0;
         accepted_count <= '0;
      end else begin
         step_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state          <= PULSE;
                  g              <= G_ONE;
                  pulseOut       <= 1'b1;
                  step_valid     <= 1'b1;
                  accepted_count <= accepted_count + ACC_ONE;
               end
            end
            PULSE: begin
               g <= g + G_ONE;
               if (g == G_PW) begin
                  pulseOut <= 1'b0;
                  state    <= GAP;
               end
            end
            GAP: begin
               if (g == G_GAP) begin
                  state <= IDLE;
                  g     <= '0;
               end else begin
                  g <= g + G_ONE;
               end
            end
            default: begin
               state    <= IDLE;
               g        <= '0;
               pulseOut <= 1'b0;
            end
         endcase
      end
   end

   // Any rise not taken by IDLE (busy or disabled) is counted, never queued.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         reject_count <= '0;
      end else if (rise && !accept && (reject_count != REJ_MAX)) begin
         reject_count <= reject_count + 8'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_conditioner.sv
// =============================================================================
// tb_step_pulse_conditioner -- directed + random checks against a window model
// Revision 1.0
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_step_pulse_conditioner;

   localparam int SYNC = 2;
   localparam int DEB  = 4;
   localparam int PW   = 3;
   localparam int GAP  = 20;
   localparam int CW   = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          raw_step;
   logic          enable;
   logic          pulseOut;
   logic          step_valid;
   logic          debounced;
   logic [CW-1:0] accepted_count;
   logic [7:0]    reject_count;

   always #5 clk = ~clk;

   step_pulse_conditioner #(
      .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .PULSE_WIDTH(PW),
      .MIN_GAP_CYCLES(GAP), .CNT_W(CW)
   ) dut (
      .clk(clk), .reset(reset), .raw_step(raw_step), .enable(enable),
      .pulseOut(pulseOut), .step_valid(step_valid), .debounced(debounced),
      .accepted_count(accepted_count), .reject_count(reject_count)
   );

   int    compared   = 0;
   int    mismatched = 0;
   string phase      = "init";

   // Model: raw samples per edge since reset; debounced follows a full window of equal s.
   logic raw_log[$];
   logic deb_log[$];
   int   n;
   int   last_a;
   bit   have_a;
   int   acc;
   int   rej;
   logic exp_sv, exp_pulse, exp_deb;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic raw_at(input int i);
      if (i < 0 || i >= raw_log.size()) return 1'b0;
      return raw_log[i];
   endfunction

   function automatic logic deb_at(input int i);
      if (i < 0 || i >= deb_log.size()) return 1'b0;
      return deb_log[i];
   endfunction

   task automatic model_reset();
      raw_log.delete();
      deb_log.delete();
      n = 0; last_a = 0; have_a = 0; acc = 0; rej = 0;
      exp_sv = 1'b0; exp_pulse = 1'b0; exp_deb = 1'b0;
   endtask

   task automatic model_edge(input logic r, input logic en);
      bit   all1, all0;
      logic d, rise;
      raw_log.push_back(r);
      all1 = 1; all0 = 1;
      for (int i = 0; i < DEB; i++) begin
         if (raw_at(n - SYNC - i)) all0 = 0; else all1 = 0;
      end
      d = all1 ? 1'b1 : (all0 ? 1'b0 : deb_at(n - 1));
      deb_log.push_back(d);
      rise   = deb_at(n - 2) & ~deb_at(n - 3);
      exp_sv = 1'b0;
      if (rise) begin
         if (en && (!have_a || (n - last_a) > GAP)) begin
            acc++; last_a = n; have_a = 1; exp_sv = 1'b1;
         end else if (rej < 255) begin
            rej++;
         end
      end
      exp_pulse = have_a && ((n - last_a) < PW);
      exp_deb   = d;
      n++;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " step_valid"}, step_valid, exp_sv);
      chk({tag, " pulseOut"}, pulseOut, exp_pulse);
      chk({tag, " debounced"}, debounced, exp_deb);
      chk({tag, " accepted"}, accepted_count, acc % (1 << CW));
      chk({tag, " rejected"}, reject_count, rej);
   endtask

   task automatic cycle(input logic r, input logic en);
      raw_step = r;
      enable   = en;
      @(posedge clk);
      model_edge(r, en);
      @(negedge clk);
      check_all(phase);
   endtask

   task automatic run(input logic r, input logic en, input int k);
      repeat (k) cycle(r, en);
   endtask

   // Called at a negedge; reset takes effect without waiting for a clock.
   task automatic apply_reset(input int cycles);
      reset = 1'b0;
      #1;
      model_reset();
      check_all({phase, " async_rst"});
      repeat (cycles) begin
         @(posedge clk);
         @(negedge clk);
         check_all({phase, " in_rst"});
      end
      reset = 1'b1;
   endtask

   int sv_at;
   int pc;
   bit deb_seen;

   initial begin
      reset = 1'b0; raw_step = 1'b0; enable = 1'b1;
      @(negedge clk);

      phase = "t1";
      apply_reset(5);
      run(1'b0, 1'b1, 50);
      chk("t1 idle acc", accepted_count, 0);

      phase = "t2";
      apply_reset(2);
      sv_at = -1; pc = 0;
      for (int i = 0; i < 40; i++) begin
         cycle((i < 10) ? 1'b1 : 1'b0, 1'b1);
         if (step_valid === 1'b1 && sv_at < 0) sv_at = i;
         if (pulseOut === 1'b1) pc++;
      end
      chk("t2 latency", sv_at, 7);
      chk("t2 pulse width", pc, 3);
      chk("t2 acc", accepted_count, 1);

      phase = "t3";
      apply_reset(2);
      deb_seen = 0;
      for (int i = 0; i < 28; i++) begin
         cycle((i < 2 || (i >= 3 && i < 6)) ? 1'b1 : 1'b0, 1'b1);
         if (debounced === 1'b1) deb_seen = 1;
      end
      chk("t3 deb never", deb_seen, 0);
      chk("t3 acc", accepted_count, 0);
      chk("t3 rej", reject_count, 0);

      phase = "t4";
      apply_reset(2);
      run(1'b1, 1'b1, 6); run(1'b0, 1'b1, 4);
      run(1'b1, 1'b1, 6); run(1'b0, 1'b1, 9);
      run(1'b1, 1'b1, 6); run(1'b0, 1'b1, 30);
      chk("t4 acc", accepted_count, 2);
      chk("t4 rej", reject_count, 1);

      phase = "t5";
      apply_reset(2);
      pc = 0;
      for (int i = 0; i < 18; i++) begin
         cycle((i < 8) ? 1'b1 : 1'b0, 1'b0);
         if (pulseOut === 1'b1) pc++;
      end
      chk("t5 no pulse", pc, 0);
      chk("t5 rej", reject_count, 1);
      run(1'b1, 1'b1, 8); run(1'b0, 1'b1, 30);
      chk("t5 acc", accepted_count, 1);

      phase = "t6";
      apply_reset(2);
      run(1'b1, 1'b1, 9);
      chk("t6 mid pulse", pulseOut, 1);
      apply_reset(3);
      chk("t6 rst acc", accepted_count, 0);
      sv_at = -1;
      for (int i = 0; i < 12; i++) begin
         cycle(1'b1, 1'b1);
         if (step_valid === 1'b1 && sv_at < 0) sv_at = i;
      end
      chk("t6 latency", sv_at, 7);
      chk("t6 acc", accepted_count, 1);
      run(1'b0, 1'b1, 25);

      phase = "rand";
      apply_reset(2);
      while (n < 3000) begin
         run(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0), $urandom_range(1, 12));
      end

      phase = "sat";
      apply_reset(2);
      repeat (270) begin
         run(1'b1, 1'b0, 6);
         run(1'b0, 1'b0, 6);
      end
      chk("sat rej", reject_count, 255);
      run(1'b1, 1'b1, 8); run(1'b0, 1'b1, 25);
      chk("sat acc", accepted_count, 1);
      chk("sat rej hold", reject_count, 255);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
